// File: rtl/anemo_freq_meter_if.sv
// ----------------------------------------------------------------------------
// anemo_freq_meter_if
//  Avalon-MM slave bus bundle for the anemometer frequency meter.
//  Signals:
//    chipselect  slave select
//    address     word address (0=CONFIG, 1=DATA, 2..3 reserved)
//    write_n     active-low write strobe, qualified by chipselect
//    writedata   32-bit write data
//    readdata    32-bit registered read data
//  Modports:
//    master  the CPU / bus fabric side (drives the request, samples readdata)
//    slave   the meter side (samples the request, drives readdata)
// ----------------------------------------------------------------------------
interface anemo_freq_meter_if;
    logic        chipselect;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/anemo_freq_meter.sv
// ----------------------------------------------------------------------------
// anemo_freq_meter
//  Counts rising edges of the asynchronous anemometer pulse over a fixed gate
//  window and reports the count (Hz for a 1 s gate) to the CPU over Avalon-MM.
//  Parameters:
//    GATE_CYCLES  clk cycles per gate window
//    CNT_W        width of the frequency result (<= 8, valid/overflow live at
//                 DATA bits 8 and 9); the result saturates at 2^CNT_W-1
//  Ports:
//    clk      system clock
//    reset    synchronous, active-high reset
//    bus      Avalon-MM slave (chipselect, address, write_n, writedata, readdata)
//    freq_in  raw anemometer pulse, asynchronous to clk
//  Register map:
//    0 CONFIG (RW): bit0 start_stop, bit1 continu, bit2 clear (self-clearing)
//    1 DATA   (RO): [CNT_W-1:0] freq, [8] data_valid, [9] overflow
//    2..3     reserved, read 0, writes ignored
// ----------------------------------------------------------------------------
module anemo_freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    anemo_freq_meter_if.slave       bus,
    input  logic                    freq_in
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    logic              sync1, sync2, sync3;
    logic              start_stop;
    logic              continu;
    logic [CNT_W-1:0]  freq;
    logic              data_valid;
    logic              overflow;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              ovf_pending;
    logic [31:0]       readdata_q;

    logic              edge_pulse;
    logic              cfg_write;
    logic              cnt_at_max;
    logic [CNT_W-1:0]  close_cnt;
    logic              close_ovf;
    logic [31:0]       read_word;
    logic              unused_wdata;

    // sync2 is the first metastability-safe copy of the pin; comparing it with
    // one more delayed copy gives a single-cycle pulse per rising edge.
    assign edge_pulse = sync2 & ~sync3;

    // Only CONFIG is writable; DATA and the reserved words ignore writes.
    assign cfg_write = bus.chipselect & ~bus.write_n & (bus.address == 2'd0);

    // Value committed at the end of a window. An edge pulse that lands on the
    // closing cycle still belongs to that window, so it is folded in here with
    // the same saturation rule used while counting.
    assign cnt_at_max = (edge_cnt == CNT_MAX);
    assign close_cnt  = (edge_pulse && !cnt_at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign close_ovf  = ovf_pending | (edge_pulse & cnt_at_max);

    // Upper write-data bits carry no function.
    assign unused_wdata = ^bus.writedata[31:3];

    assign bus.readdata = readdata_q;

    // Read multiplexer. The clear bit is never stored, so CONFIG always
    // reports it as 0.
    always_comb begin
        read_word = '0;
        case (bus.address)
            2'd0: begin
                read_word[0] = start_stop;
                read_word[1] = continu;
            end
            2'd1: begin
                read_word[CNT_W-1:0] = freq;
                read_word[8]         = data_valid;
                read_word[9]         = overflow;
            end
            default: read_word = '0;
        endcase
    end

    // Main sequential block: input synchroniser, registered read port, CONFIG
    // register and the measurement FSM. A clear write overrides the FSM for
    // that cycle and drops everything back to an empty IDLE; the mode bits of
    // the same write are still stored. The FSM always looks at the registered
    // CONFIG, so a start written on one edge begins measuring one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            readdata_q  <= '0;
            start_stop  <= 1'b0;
            continu     <= 1'b0;
            freq        <= '0;
            data_valid  <= 1'b0;
            overflow    <= 1'b0;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf_pending <= 1'b0;
            state       <= IDLE;
        end else begin
            sync1      <= freq_in;
            sync2      <= sync1;
            sync3      <= sync2;
            readdata_q <= read_word;

            if (cfg_write) begin
                start_stop <= bus.writedata[0];
                continu    <= bus.writedata[1];
            end

            if (cfg_write && bus.writedata[2]) begin
                freq        <= '0;
                data_valid  <= 1'b0;
                overflow    <= 1'b0;
                gate_cnt    <= '0;
                edge_cnt    <= '0;
                ovf_pending <= 1'b0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        gate_cnt    <= '0;
                        edge_cnt    <= '0;
                        ovf_pending <= 1'b0;
                        if (continu || start_stop) begin
                            state <= MEASURE;
                        end
                    end

                    MEASURE: begin
                        if (!continu && !start_stop) begin
                            // Mode dropped mid-window: discard the partial count
                            // but leave the last published frequency readable.
                            data_valid  <= 1'b0;
                            gate_cnt    <= '0;
                            edge_cnt    <= '0;
                            ovf_pending <= 1'b0;
                            state       <= IDLE;
                        end else if (gate_cnt == GATE_LAST) begin
                            freq        <= close_cnt;
                            overflow    <= close_ovf;
                            data_valid  <= 1'b1;
                            gate_cnt    <= '0;
                            edge_cnt    <= '0;
                            ovf_pending <= 1'b0;
                            // Continuous mode rolls straight into the next
                            // window with no dead cycle.
                            if (!continu) begin
                                state <= DONE;
                            end
                        end else begin
                            gate_cnt <= gate_cnt + GATE_W'(1);
                            if (edge_pulse) begin
                                if (cnt_at_max) begin
                                    ovf_pending <= 1'b1;
                                end else begin
                                    edge_cnt <= edge_cnt + CNT_W'(1);
                                end
                            end
                        end
                    end

                    DONE: begin
                        // Single shot holds its result until start_stop is
                        // released, which re-arms for the next 0->1 transition.
                        if (!start_stop) begin
                            data_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
